cordic_vectoring_iter: RTL and testbench
========================================

// Module: cordic_vectoring_iter
// PURPOSE
//  Iterative CORDIC in vectoring mode. It converts one signed I/Q sample into a phase angle and an
//  uncorrected magnitude, using one micro-rotation per clock. It generalises the single-step phase
//  estimator: widths and iteration count are parametrised, inputs in all four quadrants are handled,
//  and valid/ready handshakes are added on both sides. It sits between the baseband I/Q front end
//  and the O-QPSK phase/frequency tracking logic.
// PARAMETERS
//  IQ_W    8   width of signed I/Q inputs (two's complement), legal 4..16
//  ANG_W   16  width of signed binary-angle output (2^ANG_W LSB = 360 deg), legal 8..16
//  N_ITER  8   number of micro-rotations, legal 1..16
// PORTS
//  clock    in   1        system clock, rising edge
//  reset    in   1        synchronous, active-high reset
//  i_valid  in   1        upstream sample valid
//  o_ready  out  1        block can accept a sample (high only in IDLE)
//  i_I      in   IQ_W     signed in-phase sample
//  i_Q      in   IQ_W     signed quadrature sample
//  o_valid  out  1        result valid; held until accepted
//  i_ready  in   1        downstream accepts result
//  o_angle  out  ANG_W    signed phase, -180..+180 deg, wraps mod 2^ANG_W
//  o_mag    out  IQ_W+2   unsigned magnitude * K (K~1.6468, not corrected)
//  o_busy   out  1        high in ROTATE or DONE
// BEHAVIOUR
//  Reset (sync, clock edge with reset=1): state=IDLE, o_valid=0, o_ready=1, o_busy=0,
//   o_angle=0, o_mag=0, iteration counter=0. Reset wins over every other event, mid-op included.
//  Internal x,y: signed IQ_W+3 bits (no overflow incl. -2^(IQ_W-1)); z: signed ANG_W bits.
//  ATAN table: 16 fixed constants at 16-bit scale: 8192,4836,2555,1297,651,326,163,81,41,20,10,5,3,1,1,0.
//   Entry k is used as tab[k] >>> (16-ANG_W).
//  FSM:
//   IDLE: o_ready=1. On i_valid&&o_ready, load pre-rotation, k<=0, ->ROTATE. Else stay.
//    Pre-rotation: I>=0: (x,y,z)=(I,Q,0)
//                  I<0,Q>=0: (x,y,z)=(Q,-I,+90deg)
//                  I<0,Q<0: (x,y,z)=(-Q,I,-90deg)
//    +90deg = 2^(ANG_W-2).
//   ROTATE: one step per cycle, k=0..N_ITER-1:
//     y>=0: x+=y>>>k; y-=x>>>k; z+=tab[k]
//     y<0:  x-=y>>>k; y+=x>>>k; z-=tab[k]
//    All right-hand sides use the old x,y. Arithmetic shifts, truncation, z wraps.
//    After step k=N_ITER-1, ->DONE; o_angle<=z, o_mag<=x[IQ_W+1:0] are registered.
//   DONE: o_valid=1, outputs stable, o_ready=0; i_valid ignored.
//    On i_ready, ->IDLE, o_valid<=0. If i_ready is low, hold indefinitely.
//  Latency: accept edge E0 -> o_valid high after edge E0+N_ITER.
//   Min period per sample: N_ITER+2 cycles.
//  Boundaries:
//   I=Q=0 -> o_angle=0, o_mag=0.
//   Negative real axis (I<0,Q=0) -> angle near +/-180; either sign is legal.
//   -2^(IQ_W-1) on either input is exact (no negation overflow).
//   o_angle/o_mag change only on the ROTATE->DONE edge; they retain their value in IDLE.
//   i_valid during ROTATE/DONE is not accepted; the upstream must hold it.
// TESTING (IQ_W=8, ANG_W=16, N_ITER=8; angle tol +/-96 LSB, mag tol +/-2)
//  1. I=100,Q=0 -> o_angle=0, o_mag=165, o_valid 8 cycles after the accept edge.
//  2. I=0,Q=100 -> o_angle=16384; I=-100,Q=-100 -> o_angle=-24576 (-135 deg), o_mag=233.
//  3. I=-128,Q=0 -> |o_angle| >= 32672 (near 180), o_mag=211; I=-128,Q=-128 -> -24576, o_mag=298.
//  4. Hold i_ready=0 for 5 cycles in DONE with i_valid=1 -> outputs and o_valid stable, o_ready=0;
//     after release, o_valid=0 next cycle and o_ready=1.
//  5. Assert reset at ROTATE step 3 -> next cycle o_valid=0, o_ready=1, o_busy=0;
//     new sample I=50,Q=50 -> 8192.
//  6. Sweep all 65536 (I,Q) pairs with i_ready=1 -> every angle within tol of atan2 model;
//     no lost or duplicate results.

Source files
------------

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter
//   Iterative vectoring-mode CORDIC. Converts one signed I/Q sample into a
//   binary phase angle and an uncorrected magnitude (scaled by the CORDIC
//   gain K ~ 1.6468), one micro-rotation per clock.
//
// Ports
//   clock    rising-edge system clock
//   reset    synchronous, active-high
//   i_valid  upstream sample valid
//   o_ready  sample can be accepted (IDLE only)
//   i_I/i_Q  signed in-phase / quadrature sample, IQ_W bits
//   o_valid  result valid, held until i_ready
//   i_ready  downstream accepts the result
//   o_angle  signed phase, 2^ANG_W LSB = 360 deg
//   o_mag    unsigned magnitude * K, IQ_W+2 bits
//   o_busy   high while rotating or holding a result
module cordic_vectoring_iter #(
  parameter int IQ_W   = 8,
  parameter int ANG_W  = 16,
  parameter int N_ITER = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [IQ_W-1:0]  i_I,
  input  logic signed [IQ_W-1:0]  i_Q,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [ANG_W-1:0] o_angle,
  output logic        [IQ_W+1:0]  o_mag,
  output logic                    o_busy
);

  // Three guard bits: the pre-rotation negates the inputs and the
  // rotations grow the vector by up to K*sqrt(2) < 4.
  localparam int XW = IQ_W + 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic signed [ANG_W-1:0] ANG_90 = signed'(ANG_W'(1 << (ANG_W - 2)));
  localparam logic [3:0]              K_LAST = 4'(N_ITER - 1);

  // atan(2^-k) at 16-bit binary-angle scale, narrowed to ANG_W.
  function automatic logic signed [ANG_W-1:0] atan_tab(input logic [3:0] k);
    logic [15:0] t;
    case (k)
      4'd0:    t = 16'd8192;
      4'd1:    t = 16'd4836;
      4'd2:    t = 16'd2555;
      4'd3:    t = 16'd1297;
      4'd4:    t = 16'd651;
      4'd5:    t = 16'd326;
      4'd6:    t = 16'd163;
      4'd7:    t = 16'd81;
      4'd8:    t = 16'd41;
      4'd9:    t = 16'd20;
      4'd10:   t = 16'd10;
      4'd11:   t = 16'd5;
      4'd12:   t = 16'd3;
      4'd13:   t = 16'd1;
      4'd14:   t = 16'd1;
      default: t = 16'd0;
    endcase
    return signed'(ANG_W'(t >> (16 - ANG_W)));
  endfunction

  function automatic logic signed [XW-1:0] sext_iq(input logic signed [IQ_W-1:0] v);
    return {{3{v[IQ_W-1]}}, v};
  endfunction

  logic [1:0]              state;
  logic [3:0]              k;
  logic signed [XW-1:0]    x, y;
  logic signed [ANG_W-1:0] z;
  logic                    zero_in;

  logic signed [XW-1:0]    i_ext, q_ext;
  logic signed [XW-1:0]    pre_x, pre_y;
  logic signed [ANG_W-1:0] pre_z;
  logic signed [XW-1:0]    x_sh, y_sh;
  logic signed [XW-1:0]    x_nx, y_nx;
  logic signed [ANG_W-1:0] z_nx;
  logic                    load, step, last;

  assign o_ready = (state == ST_IDLE);
  assign o_busy  = (state != ST_IDLE);
  assign o_valid = (state == ST_DONE);

  assign load = (state == ST_IDLE) && i_valid;
  assign step = (state == ST_ROTATE);
  assign last = (k == K_LAST);

  assign i_ext = sext_iq(i_I);
  assign q_ext = sext_iq(i_Q);

  // Pre-rotation folds the left half-plane into the right half-plane so the
  // micro-rotations only have to cover +/-99.9 deg.
  always_comb begin
    pre_x = i_ext;
    pre_y = q_ext;
    pre_z = '0;
    if (i_I[IQ_W-1]) begin
      if (!i_Q[IQ_W-1]) begin
        pre_x = q_ext;
        pre_y = -i_ext;
        pre_z = ANG_90;
      end else begin
        pre_x = -q_ext;
        pre_y = i_ext;
        pre_z = -ANG_90;
      end
    end
  end

  // One micro-rotation driving y toward zero; both updates use the old x,y.
  always_comb begin
    x_sh = x >>> k;
    y_sh = y >>> k;
    if (!y[XW-1]) begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + atan_tab(k);
    end else begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - atan_tab(k);
    end
  end

  // Control and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      k       <= 4'd0;
      o_angle <= '0;
      o_mag   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            k     <= 4'd0;
            state <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          k <= k + 4'd1;
          if (last) begin
            state <= ST_DONE;
            // A zero vector has no direction; without this the y>=0 rule
            // would walk z up through the whole table.
            o_angle <= zero_in ? '0 : z_nx;
            o_mag   <= x_nx[IQ_W+1:0];
          end
        end
        ST_DONE: begin
          if (i_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Working vector and angle accumulator.
  always_ff @(posedge clock) begin
    if (load) begin
      x       <= pre_x;
      y       <= pre_y;
      z       <= pre_z;
      zero_in <= (i_I == '0) && (i_Q == '0);
    end else if (step) begin
      x <= x_nx;
      y <= y_nx;
      z <= z_nx;
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
module tb_cordic_vectoring_iter;

  localparam int  IQ_W   = 8;
  localparam int  ANG_W  = 16;
  localparam int  N_ITER = 8;
  localparam real PI     = 3.14159265358979;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    i_valid;
  logic                    o_ready;
  logic signed [IQ_W-1:0]  i_I;
  logic signed [IQ_W-1:0]  i_Q;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [ANG_W-1:0] o_angle;
  logic        [IQ_W+1:0]  o_mag;
  logic                    o_busy;

  cordic_vectoring_iter #(.IQ_W(IQ_W), .ANG_W(ANG_W), .N_ITER(N_ITER)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_I     (i_I),
    .i_Q     (i_Q),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_angle (o_angle),
    .o_mag   (o_mag),
    .o_busy  (o_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int i;
    int q;
  } sample_t;

  sample_t sb[$];
  int      errors   = 0;
  int      checks   = 0;
  int      received = 0;
  real     kgain;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Offer a sample, wait (bounded) for acceptance, record it on the scoreboard.
  task automatic send(input string tag, input int iv, input int qv);
    int n;
    n = 0;
    i_I     = IQ_W'(iv);
    i_Q     = IQ_W'(qv);
    i_valid = 1'b1;
    while (!o_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, int'(o_ready), 1);
    tick();
    i_valid = 1'b0;
    sb.push_back('{iv, qv});
    chk({tag, "_busy"}, int'(o_busy), 1);
    chk({tag, "_noready"}, int'(o_ready), 0);
  endtask

  // Wait (bounded) for a result and compare it to the atan2/gain model.
  // strict: fixed +/-96 LSB angle window; otherwise the window widens for
  // small vectors where integer truncation dominates.
  task automatic recv(input string tag, input bit strict, input bit mag_chk);
    int      n, exp_a, d, tol;
    real     mag, ra;
    sample_t s;
    n = 0;
    while (!o_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, N_ITER);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=result expected=no_result", tag);
    end
    if (sb.size() > 0) begin
      s = sb.pop_front();
      received++;
      mag = $sqrt(real'(s.i * s.i + s.q * s.q));
      if (s.i == 0 && s.q == 0) begin
        chk({tag, "_angle0"}, int'(o_angle), 0);
        chk({tag, "_mag0"}, int'(o_mag), 0);
      end else begin
        ra    = $atan2(real'(s.q), real'(s.i)) * 32768.0 / PI;
        exp_a = int'(ra);
        d     = int'(o_angle) - exp_a;
        while (d > 32767) d -= 65536;
        while (d < -32768) d += 65536;
        tol = strict ? 96 : 96 + int'(12.0 * 10430.0 / mag);
        chk_tol({tag, "_angle"}, d, 0, tol);
        if (mag_chk) chk_tol({tag, "_mag"}, int'(o_mag), int'(kgain * mag), 4);
      end
    end
  endtask

  task automatic release_result(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_rel_valid"}, int'(o_valid), 0);
    chk({tag, "_rel_ready"}, int'(o_ready), 1);
  endtask

  initial begin
    int a_hold, m_hold;

    kgain = 1.0;
    for (int k = 0; k < N_ITER; k++) kgain = kgain * $sqrt(1.0 + 1.0 / (4.0 ** k));

    reset   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_I     = '0;
    i_Q     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_busy",  int'(o_busy),  0);
    chk("rst_angle", int'(o_angle), 0);
    chk("rst_mag",   int'(o_mag),   0);

    // Positive real axis; results retained once back in IDLE.
    send("pos_i", 100, 0);
    recv("pos_i", 1'b1, 1'b1);
    a_hold = int'(o_angle);
    m_hold = int'(o_mag);
    release_result("pos_i");
    tick();
    tick();
    chk("idle_keep_angle", int'(o_angle), a_hold);
    chk("idle_keep_mag",   int'(o_mag),   m_hold);

    send("pos_q", 0, 100);
    recv("pos_q", 1'b1, 1'b1);
    release_result("pos_q");

    send("q3", -100, -100);
    recv("q3", 1'b1, 1'b1);
    release_result("q3");

    // Extreme negative inputs and the negative real axis.
    send("neg_axis", -128, 0);
    recv("neg_axis", 1'b1, 1'b1);
    release_result("neg_axis");

    send("min_min", -128, -128);
    recv("min_min", 1'b1, 1'b1);
    release_result("min_min");

    send("zero", 0, 0);
    recv("zero", 1'b1, 1'b1);
    release_result("zero");

    // Back-pressure in DONE with a competing sample offered.
    send("hold", 30, -70);
    recv("hold", 1'b1, 1'b1);
    a_hold  = int'(o_angle);
    m_hold  = int'(o_mag);
    i_I     = 8'sd5;
    i_Q     = 8'sd5;
    i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_valid", int'(o_valid), 1);
      chk("hold_ready", int'(o_ready), 0);
      chk("hold_angle", int'(o_angle), a_hold);
      chk("hold_mag",   int'(o_mag),   m_hold);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    i_valid = 1'b0;
    chk("hold_rel_valid", int'(o_valid), 0);
    chk("hold_rel_ready", int'(o_ready), 1);

    // Reset in the middle of a rotation.
    send("mid_rst", 50, 50);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_ready", int'(o_ready), 1);
    chk("mid_rst_busy",  int'(o_busy),  0);
    chk("mid_rst_angle", int'(o_angle), 0);
    chk("mid_rst_mag",   int'(o_mag),   0);
    for (int c = 0; c < N_ITER + 2; c++) tick();
    chk("mid_rst_quiet", int'(o_valid), 0);
    send("after_rst", 50, 50);
    recv("after_rst", 1'b1, 1'b0);
    chk_tol("after_rst_8192", int'(o_angle), 8192, 96);
    release_result("after_rst");

    // Coarse sweep of the full input range, both extremes included.
    received = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send("sweep", -128 + 17 * a, -128 + 17 * b);
        recv("sweep", 1'b0, 1'b0);
        release_result("sweep");
      end
    end
    chk("sweep_count", received, 256);
    chk("sweep_sb_left", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
